// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I instruction fetch front end.
// Used by the fetch queue and by the fetch unit top level.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: 32'h0000_0000};

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instruction, pc} pairs with a registered head entry.
// Flush empties the queue and takes priority over a same-cycle push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           push_entry_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    rd_next  = rd_ptr_q + 1'b1;
    do_pop   = pop_i && (count_q != '0);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = EMPTY_ENTRY;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_next;
      end
      count_d = count_q + CW'(push_i) - CW'(do_pop);
      // The head register always mirrors the oldest stored entry, so the
      // decode-facing outputs come straight from a flop.
      if (count_d == '0) begin
        head_d = EMPTY_ENTRY;
      end else if (do_pop && count_q > CW'(1)) begin
        head_d = mem_q[rd_next];
      end else if (count_q == '0 || do_pop) begin
        head_d = push_entry_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= EMPTY_ENTRY;
      end
      head_q   <= EMPTY_ENTRY;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

  no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch front end: owns the PC, issues word-aligned memory requests under a
// credit limit, queues in-order responses and discards stale ones after a redirect.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] Instruction_o,
  output logic [31:0] PC_o,
  output logic [31:0] PC_plus4_o,
  output logic        valid_o
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] q_count;
  logic [CW:0]   occ;
  fetch_entry_t  q_head, q_push_entry;
  logic          q_push, q_flush, pop, req_fire;
  logic [31:0]   redirect_pc_aligned;

  assign valid_o             = (state_q != BOOT) && (q_count != '0);
  assign pop                 = valid_o && !stall_i;
  assign occ                 = {1'b0, outstanding_q} + {1'b0, q_count};
  assign redirect_pc_aligned = redirect_pc_i & ~32'h3;

  // Credit rule: in-flight requests plus queued instructions never exceed the
  // queue depth, so every response is guaranteed a free slot.
  assign imem_req_valid_o = (state_q == RUN) && !redirect_i &&
                            ((occ - (CW+1)'(pop)) < (CW+1)'(QUEUE_DEPTH));
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign Instruction_o = valid_o ? q_head.instr : NOP_INSTR;
  assign PC_o          = q_head.pc;
  assign PC_plus4_o    = q_head.pc + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    q_push        = 1'b0;
    q_flush       = 1'b0;
    // Outstanding requests in RUN are consecutive words ending just below pc.
    q_push_entry  = '{instr: imem_rsp_data_i, pc: pc_q - (32'(outstanding_q) << 2)};
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect_i) pc_d = redirect_pc_aligned;
      end
      RUN: begin
        if (redirect_i) begin
          pc_d          = redirect_pc_aligned;
          q_flush       = 1'b1;
          outstanding_d = '0;
          drop_d        = outstanding_q - CW'(imem_rsp_valid_i);
          state_d       = (drop_d != '0) ? FLUSH : RUN;
        end else begin
          if (req_fire) pc_d = pc_q + 32'd4;
          q_push        = imem_rsp_valid_i;
          outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
        end
      end
      FLUSH: begin
        if (redirect_i) pc_d = redirect_pc_aligned;
        drop_d = drop_q - CW'(imem_rsp_valid_i);
        if (drop_d == '0) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .pop_i       (pop),
    .flush_i     (q_flush),
    .push_entry_i(q_push_entry),
    .head_o      (q_head),
    .count_o     (q_count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-configurable in-order
// instruction memory model whose contents are a fixed function of the address.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic [31:0] Instruction_o;
  logic [31:0] PC_o;
  logic [31:0] PC_plus4_o;
  logic        valid_o;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 1;

  typedef struct {
    logic [31:0] data;
    int          cnt;
  } mem_ent_t;

  mem_ent_t pend[$];

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o (imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i (imem_rsp_data_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .stall_i         (stall_i),
    .Instruction_o   (Instruction_o),
    .PC_o            (PC_o),
    .PC_plus4_o      (PC_plus4_o),
    .valid_o         (valid_o)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  // In-order memory: a request accepted at an edge is presented mem_lat cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      imem_rsp_valid_i <= 1'b0;
      imem_rsp_data_i  <= 32'h0;
    end else begin
      if (imem_rsp_valid_i) void'(pend.pop_front());
      foreach (pend[i]) begin
        if (pend[i].cnt > 0) pend[i].cnt = pend[i].cnt - 1;
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        pend.push_back('{data: memWord(imem_req_addr_o), cnt: mem_lat - 1});
      end
      if (pend.size() > 0 && pend[0].cnt == 0) begin
        imem_rsp_valid_i <= 1'b1;
        imem_rsp_data_i  <= pend[0].data;
      end else begin
        imem_rsp_valid_i <= 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic stall, input logic redirect,
                               input logic [31:0] redirect_pc, input logic ready);
    stall_i          = stall;
    redirect_i       = redirect;
    redirect_pc_i    = redirect_pc;
    imem_req_ready_i = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd1);
    checkOutput({tag, "_pc"}, PC_o, pc);
    checkOutput({tag, "_instr"}, Instruction_o, memWord(pc));
    checkOutput({tag, "_pc4"}, PC_plus4_o, pc + 32'd4);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_nop"}, Instruction_o, 32'h0000_0013);
  endtask

  task automatic checkReq(input string tag, input logic vld, input logic [31:0] addr);
    checkOutput({tag, "_reqv"}, 32'(imem_req_valid_o), 32'(vld));
    if (vld) checkOutput({tag, "_addr"}, imem_req_addr_o, addr);
  endtask

  // Leaves the bench at the falling edge of the BOOT cycle.
  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    mem_lat = 1;
    #1 rst = 1'b1;

    // Reset values and straight-line fetch with a 1-cycle memory
    @(negedge clk);
    checkIdle("rst");
    checkOutput("rst_pc", PC_o, 32'h0);
    checkReq("rst", 1'b0, 32'h0);
    rst = 1'b0;
    #1 checkReq("boot", 1'b0, 32'h0);
    @(negedge clk);
    checkReq("c2", 1'b1, 32'h0);
    checkIdle("c2");
    @(negedge clk);
    checkReq("c3", 1'b1, 32'h4);
    checkIdle("c3");
    @(negedge clk);
    checkHead("c4", 32'h0);
    checkReq("c4", 1'b1, 32'h8);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      checkHead("stream", 32'(4 * k));
    end

    // Five stalled cycles hold the head at 0xC and stop new requests
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkHead("stall", 32'hC);
      checkReq("stall", 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkHead("resume", 32'(16 + 4 * k));
    end

    // Memory not ready for four edges: address 0x24 is held until accepted
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkHead("nrdy_drain", 32'h20);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) @(negedge clk);
      checkReq("nrdy_hold", 1'b1, 32'h24);
    end
    checkIdle("nrdy_empty");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkIdle("nrdy_wait");
    checkReq("nrdy_next", 1'b1, 32'h28);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkHead("nrdy_resume", 32'(36 + 4 * k));
    end

    // Asynchronous reset between clock edges clears the outputs at once
    #2 rst = 1'b1;
    #1;
    checkIdle("arst");
    checkOutput("arst_pc", PC_o, 32'h0);
    checkReq("arst", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkReq("arst_c2", 1'b1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkHead("arst_c4", 32'h0);

    // Redirect to 0x203 while the only outstanding response is arriving
    resetDut();
    @(negedge clk);
    checkReq("rdr1_c2", 1'b1, 32'h0);
    @(negedge clk);
    checkReq("rdr1_c3", 1'b1, 32'h4);
    applyStimulus(1'b0, 1'b1, 32'h203, 1'b1);
    #1 checkReq("rdr1_same", 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkReq("rdr1_c4", 1'b1, 32'h200);
    checkIdle("rdr1_c4");
    @(negedge clk);
    checkIdle("rdr1_c5");
    @(negedge clk);
    checkHead("rdr1_c6", 32'h200);
    @(negedge clk);
    checkHead("rdr1_c7", 32'h204);

    // Redirect to 0x100 with two responses outstanding on a 3-cycle memory
    mem_lat = 3;
    resetDut();
    @(negedge clk);
    checkReq("rdr2_c2", 1'b1, 32'h0);
    @(negedge clk);
    checkReq("rdr2_c3", 1'b1, 32'h4);
    @(negedge clk);
    checkReq("rdr2_c4", 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkReq("rdr2_flush1", 1'b0, 32'h0);
    checkIdle("rdr2_flush1");
    @(negedge clk);
    checkReq("rdr2_flush2", 1'b0, 32'h0);
    checkIdle("rdr2_flush2");
    @(negedge clk);
    checkReq("rdr2_c7", 1'b1, 32'h100);
    @(negedge clk);
    checkReq("rdr2_c8", 1'b1, 32'h104);
    @(negedge clk);
    checkIdle("rdr2_c9");
    @(negedge clk);
    checkIdle("rdr2_c10");
    @(negedge clk);
    checkHead("rdr2_c11", 32'h100);
    @(negedge clk);
    checkHead("rdr2_c12", 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the RV32I pipeline: owns the PC and issues word-aligned requests to instruction memory.
- Buffers the in-order responses in a small fetch queue and presents {instruction, PC, PC+4, valid} to the decode stage.
- Honours decode-stage stalls and execute-stage redirects (taken branches, JAL/JALR), discarding stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- QUEUE_DEPTH, 2, fetch queue entries; also the maximum in-flight requests plus queued instructions (power of two, ≥2).

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- imem_req_valid_o  output  1  Fetch request valid.
- imem_req_ready_i  input  1  Memory accepts the request this cycle.
- imem_req_addr_o  output  32  Request address; bits [1:0] are always 0.
- imem_rsp_valid_i  input  1  Response valid. Responses arrive in order, exactly one per accepted request, at least 1 cycle after acceptance, and cannot be back-pressured.
- imem_rsp_data_i  input  32  Instruction word.
- redirect_i  input  1  Redirect request from execute.
- redirect_pc_i  input  32  Redirect target; bits [1:0] ignored and forced to 0.
- stall_i  input  1  Decode cannot accept an instruction this cycle.
- Instruction_o  output  32  Queue-head instruction; 32'h0000_0013 (NOP) when valid_o=0.
- PC_o  output  32  PC of the queue-head instruction.
- PC_plus4_o  output  32  PC_o+4, modulo 2^32.
- valid_o  output  1  Queue non-empty and the FSM is not in BOOT.

Behaviour:
- Reset values: pc=RESET_PC, imem_req_valid_o=0, queue empty, valid_o=0, Instruction_o=NOP, PC_o=0, outstanding=0, drop=0, state=BOOT.
- FSM states:
  - BOOT: lasts one cycle after reset deassertion, issues no request, then moves to RUN.
  - RUN: normal fetching.
  - FLUSH: waits for stale responses to drain.
- Definitions:
  - pop = valid_o && !stall_i.
  - occ = outstanding + queue_count.
- Request issue (RUN only, no redirect this cycle): imem_req_valid_o = (occ − pop) < QUEUE_DEPTH. imem_req_addr_o = pc. On request valid && ready, pc += 4 (wraps at 2^32) and outstanding += 1. The request holds address and valid stable until accepted unless a redirect occurs.
- Response in RUN: push {data, pc_of_request} into the queue and decrement outstanding. Each queue entry carries its own PC, taken from an internal PC-of-oldest-outstanding tracker.
- Latency: a request accepted in cycle N with its response in N+1 gives valid_o in N+2. There is no response-to-output bypass.
- Throughput: with 1-cycle memory, 1 instruction per cycle when stall_i=0.
- Pop and push in the same cycle are legal. The credit rule guarantees the queue never overflows; a push while full is an assertion failure.
- Redirect in RUN:
  - imem_req_valid_o=0 in that cycle; pc <= redirect_pc_i & ~3; queue is flushed; valid_o=0 the next cycle.
  - drop <= outstanding − (imem_rsp_valid_i ? 1 : 0); any same-cycle response is discarded.
  - Next state is FLUSH if drop>0, otherwise RUN.
- FLUSH:
  - No requests are issued.
  - Each response decrements drop and is discarded.
  - When drop reaches 0, go to RUN next cycle.
  - A redirect in FLUSH updates pc only; drop is unaffected.
- A redirect in the same cycle as pop: the popped instruction counts as consumed; the flush still applies to the remaining entries.
- A redirect in BOOT updates pc; the FSM still goes to RUN.
- Asynchronous reset mid-operation returns everything to reset values immediately. The memory side must also be reset, so no stale responses survive reset.
- stall_i holds Instruction_o, PC_o and valid_o stable.

Decomposition:
- fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Fetch FSM enum {BOOT, RUN, FLUSH}.
  - Queue entry struct {instr[31:0], pc[31:0]}.
- Sub-module fetch_queue:
  - Synchronous FIFO with depth QUEUE_DEPTH, push/pop/flush, count output and registered head.
  - Flush has priority over push.

Test Plan:
- Reset release, 1-cycle memory always ready, stall_i=0 → first request addr 0x0 in cycle 2 after reset; valid_o first seen in cycle 4 with PC_o=0x0; then PC_o=0x4, 0x8, … one per cycle.
- stall_i=1 for 5 cycles mid-stream → outputs held; imem_req_valid_o drops once occ=2; resumes without loss or duplication of PCs.
- Redirect to 0x100 with 2 responses outstanding and 3-cycle memory latency → both stale responses discarded (FLUSH for ≥2 cycles); next valid_o shows PC_o=0x100, then 0x104.
- Redirect to 0x203 in the same cycle as a response arrives, outstanding=1 → response dropped, no FLUSH entered, next fetch addr 0x200.
- imem_req_ready_i low for 4 cycles → address held at its value; pc increments only on acceptance; outputs show no gaps or duplicates afterwards.
- Asynchronous rst pulse mid-stream, asserted between clock edges → valid_o=0 and Instruction_o=NOP immediately; fetch restarts at RESET_PC.
